cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: LINE_WIDTH, 256, width of one cache line in bits.
REQ-002 Reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 i_read  input  1  instruction-cache line read request; held until i_resp.
REQ-006 i_address  input  32  instruction-cache line address, line-aligned.
REQ-007 i_rdata  output  LINE_WIDTH  line returned to the instruction cache.
REQ-008 i_resp  output  1  one-cycle completion pulse to the instruction cache.
REQ-009 d_read  input  1  data-cache line read request; held until d_resp.
REQ-010 d_write  input  1  data-cache line write-back request; held until d_resp.
REQ-011 d_address  input  32  data-cache line address.
REQ-012 d_wdata  input  LINE_WIDTH  write-back line.
REQ-013 d_rdata  output  LINE_WIDTH  line returned to the data cache.
REQ-014 d_resp  output  1  one-cycle completion pulse to the data cache.
REQ-015 pmem_read / pmem_write  output  1 each  request to the shared L2/physical memory port.
REQ-016 pmem_address  output  32  address on the shared port.
REQ-017 pmem_wdata  output  LINE_WIDTH  write line on the shared port.
REQ-018 pmem_rdata  input  LINE_WIDTH  read line from the shared port.
REQ-019 pmem_resp  input  1  completion from the shared port.

Function
REQ-020 The FSM SHALL have three states: IDLE, SERVE_I and SERVE_D.
REQ-021 In IDLE, all pmem_* control outputs SHALL be 0, and i_resp and d_resp SHALL be 0.
REQ-022 In IDLE, a pending request (i_read, or d_read|d_write) SHALL move the FSM to the matching SERVE state on the next edge.
REQ-023 When both caches request in IDLE, the grant SHALL go to the requester that was not granted last (round-robin).
REQ-024 The last_grant register SHALL update only on a transition out of IDLE.
REQ-025 In SERVE_I: pmem_read=1, pmem_write=0, pmem_address=i_address.
REQ-026 In SERVE_D: pmem_read=d_read, pmem_write=d_write, pmem_address=d_address, pmem_wdata=d_wdata.
REQ-027 pmem_* outputs SHALL be combinational from the state and the granted requester's inputs, so the first request cycle is the cycle after acceptance.
REQ-028 pmem_rdata SHALL be forwarded to both i_rdata and d_rdata at all times.
REQ-029 In a SERVE state, pmem_resp=1 SHALL assert the granted requester's resp in the same cycle; the FSM SHALL return to IDLE on the next edge.
REQ-030 The other requester's resp SHALL remain 0 throughout.
REQ-031 The mandatory IDLE cycle after each completion SHALL prevent re-issuing a request whose resp was just delivered.
REQ-032 The granted requester dropping its request before pmem_resp is a protocol violation; the FSM SHALL still hold the SERVE state until pmem_resp.
REQ-033 Requests arriving at a non-granted requester during a SERVE state SHALL wait and SHALL NOT disturb pmem_* outputs.
REQ-034 d_read and d_write asserted together is illegal; d_write SHALL take precedence, giving pmem_read=0.
REQ-035 Minimum occupancy per transaction SHALL be 2 cycles: the SERVE state plus IDLE.

Reset
REQ-036 rst=1 at a rising edge SHALL force state to IDLE and last_grant to D, so that the first contention grants I.
REQ-037 Reset during a SERVE state SHALL abandon the transaction: pmem_read and pmem_write SHALL be 0 the cycle after reset, and no resp SHALL be generated.
REQ-038 Outputs SHALL equal IDLE values while rst is held.

Verification
REQ-039 Lone I-fetch: i_read=1, i_address=0x60; pmem_resp pulses 3 cycles later with rdata=0xA5..A5 -> pmem_read=1 with address 0x60 from the cycle after the request; i_resp=1 with i_rdata=0xA5..A5 in the resp cycle; d_resp=0.
REQ-040 D write-back: d_write=1, d_address=0x1000, d_wdata=0x1234 -> pmem_write=1, pmem_address=0x1000, pmem_wdata=0x1234 until pmem_resp; d_resp pulses once.
REQ-041 Contention after reset: i_read and d_read both rise together -> I is served first; D is granted on the IDLE cycle after i_resp.
REQ-042 Sustained contention: both requesting continuously for 6 transactions -> grants strictly alternate I, D, I, D, I, D; each resp is exactly 1 cycle.
REQ-043 Mid-transaction reset: rst=1 in SERVE_D before pmem_resp -> pmem_write=0 next cycle, no d_resp, FSM in IDLE.
REQ-044 Back-to-back single requester: d_read held again immediately after d_resp -> exactly one IDLE bubble, then a new pmem_read.

Source files
------------

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter that shares one line-wide memory
// port between the instruction cache and the data cache.
module cache_arbiter #(
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [31:0]           i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [31:0]           d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [31:0]           pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_d_q, last_d_d;
    logic   d_req;

    assign d_req = d_read | d_write;

    // Read data goes to both caches; only the resp pulse qualifies it.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // Next state; last_d only moves when IDLE hands out a grant.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        unique case (state_q)
            IDLE: begin
                if (i_read && (!d_req || last_d_q)) begin
                    state_d  = SERVE_I;
                    last_d_d = 1'b0;
                end else if (d_req) begin
                    state_d  = SERVE_D;
                    last_d_d = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and grant history; reset favours I on the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // Memory port and resp steering; forced idle while rst is high.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        if (!rst) begin
            unique case (state_q)
                SERVE_I: begin
                    pmem_read    = 1'b1;
                    pmem_address = i_address;
                    i_resp       = pmem_resp;
                end
                SERVE_D: begin
                    pmem_read    = d_read & ~d_write;
                    pmem_write   = d_write;
                    pmem_address = d_address;
                    pmem_wdata   = d_wdata;
                    d_resp       = pmem_resp;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: cycle table for the single-transaction corners plus
// a scoreboarded run of sustained I/D contention.
module tb_cache_arbiter;

    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [31:0]   i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [31:0]   d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [31:0]   pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int total = 0;
    int bad   = 0;

    cache_arbiter #(.LINE_WIDTH(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        pr;
        logic [7:0]  prb;
        logic        er;
        logic        ew;
        logic [31:0] ea;
        logic        eir;
        logic        edr;
    } vec_t;

    typedef struct {
        logic          is_d;
        logic [LW-1:0] data;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];

    function automatic vec_t v(
        logic r, logic ir, logic [31:0] ia,
        logic dr, logic dw, logic [31:0] da, logic [31:0] dwd,
        logic pr, logic [7:0] prb,
        logic er, logic ew, logic [31:0] ea, logic eir, logic edr
    );
        vec_t t;
        t.rst = r;   t.ir = ir;   t.ia = ia;
        t.dr = dr;   t.dw = dw;   t.da = da;  t.dwd = dwd;
        t.pr = pr;   t.prb = prb;
        t.er = er;   t.ew = ew;   t.ea = ea;
        t.eir = eir; t.edr = edr;
        return t;
    endfunction

    task automatic chk(string name, logic [LW-1:0] act,
                       logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
    endtask

    initial begin
        sb_t         e;
        int          busy;
        logic        prev_resp;
        logic [31:0] w;

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // reset held, then a lone I fetch
        tbl.push_back(v(1,1,32'h60,0,0,0,0,0,8'h11,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,8'h22,0,0,0,0,0));
        tbl.push_back(v(0,1,32'h60,0,0,0,0,0,8'h33,0,0,0,0,0));
        tbl.push_back(v(0,1,32'h60,0,0,0,0,0,8'h44,1,0,32'h60,0,0));
        tbl.push_back(v(0,1,32'h60,0,0,0,0,0,8'h55,1,0,32'h60,0,0));
        tbl.push_back(v(0,1,32'h60,0,0,0,0,1,8'hA5,1,0,32'h60,1,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,8'h66,0,0,0,0,0));
        // D write-back
        tbl.push_back(v(0,0,0,0,1,32'h1000,32'h1234,0,8'h01,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,1,32'h1000,32'h1234,0,8'h02,
                        0,1,32'h1000,0,0));
        tbl.push_back(v(0,0,0,0,1,32'h1000,32'h1234,1,8'h03,
                        0,1,32'h1000,0,1));
        tbl.push_back(v(0,0,0,0,0,0,0,0,8'h04,0,0,0,0,0));
        // back-to-back D reads: one IDLE bubble
        tbl.push_back(v(0,0,0,1,0,32'h2000,0,0,8'h05,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,0,32'h2000,0,1,8'h06,1,0,32'h2000,0,1));
        tbl.push_back(v(0,0,0,1,0,32'h2000,0,0,8'h07,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,0,32'h2000,0,0,8'h08,1,0,32'h2000,0,0));
        tbl.push_back(v(0,0,0,1,0,32'h2000,0,1,8'h09,1,0,32'h2000,0,1));
        tbl.push_back(v(0,0,0,0,0,0,0,0,8'h0A,0,0,0,0,0));
        // reset in the middle of SERVE_D
        tbl.push_back(v(0,0,0,0,1,32'h3000,32'h77,0,8'h0B,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,1,32'h3000,32'h77,0,8'h0C,
                        0,1,32'h3000,0,0));
        tbl.push_back(v(1,0,0,0,1,32'h3000,32'h77,0,8'h0D,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,1,8'h0E,0,0,0,0,0));
        // contention after reset: I first, D on the IDLE after i_resp
        tbl.push_back(v(0,1,32'h80,1,0,32'h4000,0,0,8'h0F,0,0,0,0,0));
        tbl.push_back(v(0,1,32'h80,1,0,32'h4000,0,0,8'h10,
                        1,0,32'h80,0,0));
        tbl.push_back(v(0,1,32'h80,1,0,32'h4000,0,1,8'h12,
                        1,0,32'h80,1,0));
        tbl.push_back(v(0,0,0,1,0,32'h4000,0,0,8'h13,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,0,32'h4000,0,0,8'h14,
                        1,0,32'h4000,0,0));
        tbl.push_back(v(0,0,0,1,0,32'h4000,0,1,8'h15,
                        1,0,32'h4000,0,1));
        tbl.push_back(v(0,0,0,0,0,0,0,0,8'h16,0,0,0,0,0));
        // d_read with d_write: write wins
        tbl.push_back(v(0,0,0,1,1,32'h5000,32'h99,0,8'h17,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,1,32'h5000,32'h99,0,8'h18,
                        0,1,32'h5000,0,0));
        tbl.push_back(v(0,0,0,1,1,32'h5000,32'h99,1,8'h19,
                        0,1,32'h5000,0,1));
        tbl.push_back(v(0,0,0,0,0,0,0,0,8'h1A,0,0,0,0,0));
        // I drops its request mid-serve: SERVE_I held until resp
        tbl.push_back(v(0,1,32'h90,0,0,0,0,0,8'h1B,0,0,0,0,0));
        tbl.push_back(v(0,0,32'h90,0,0,0,0,0,8'h1C,1,0,32'h90,0,0));
        tbl.push_back(v(0,0,32'h90,0,0,0,0,1,8'h1D,1,0,32'h90,1,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,8'h1E,0,0,0,0,0));

        foreach (tbl[k]) begin
            @(posedge clk);
            #1;
            rst        = tbl[k].rst;
            i_read     = tbl[k].ir;
            i_address  = tbl[k].ia;
            d_read     = tbl[k].dr;
            d_write    = tbl[k].dw;
            d_address  = tbl[k].da;
            d_wdata    = LW'(tbl[k].dwd);
            pmem_resp  = tbl[k].pr;
            pmem_rdata = {32{tbl[k].prb}};
            @(negedge clk);
            chk($sformatf("r%0d pmem_read", k), pmem_read, tbl[k].er);
            chk($sformatf("r%0d pmem_write", k), pmem_write, tbl[k].ew);
            if (tbl[k].er || tbl[k].ew)
                chk($sformatf("r%0d pmem_address", k), pmem_address,
                    tbl[k].ea);
            if (tbl[k].ew)
                chk($sformatf("r%0d pmem_wdata", k), pmem_wdata,
                    LW'(tbl[k].dwd));
            chk($sformatf("r%0d i_resp", k), i_resp, tbl[k].eir);
            chk($sformatf("r%0d d_resp", k), d_resp, tbl[k].edr);
            chk($sformatf("r%0d i_rdata", k), i_rdata, {32{tbl[k].prb}});
            chk($sformatf("r%0d d_rdata", k), d_rdata, {32{tbl[k].prb}});
        end

        // sustained contention: grants must alternate I, D, ...
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_read = 1'b1; i_address = 32'h100;
        d_read = 1'b1; d_address = 32'h200;
        for (int n = 0; n < 6; n++) begin
            e.is_d = n[0];
            w = n[0] ? 32'h200 : 32'h100;
            e.data = {8{w}};
            sb.push_back(e);
        end
        busy = 0;
        prev_resp = 1'b0;
        for (int cyc = 0; cyc < 100 && sb.size() > 0; cyc++) begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (pmem_read || pmem_write) begin
                busy++;
                if (busy == 3) begin
                    busy = 0;
                    pmem_resp = 1'b1;
                    pmem_rdata = {8{pmem_address}};
                end
            end else begin
                busy = 0;
            end
            @(negedge clk);
            if (i_resp || d_resp) begin
                e = sb.pop_front();
                chk("sb_excl", i_resp & d_resp, 1'b0);
                chk("sb_who", d_resp, e.is_d);
                chk("sb_rdata", d_resp ? d_rdata : i_rdata, e.data);
                chk("sb_pulse", prev_resp, 1'b0);
            end
            prev_resp = i_resp | d_resp;
        end
        chk("sb_drained", LW'(sb.size()), '0);

        @(posedge clk);
        #1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("final_idle_read", pmem_read, 1'b0);
        chk("final_idle_resp", i_resp | d_resp, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
